tx_sequencer: RTL and testbench

//  Run/stop sequencer for the I/Q Tx chain (prbs9 -> polyph_filter).

---
 rtl/tx_sequencer.sv | 133 +++++++++++++
 tb/tb_tx_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/tx_sequencer.sv
// rtl/tx_sequencer.sv - run/stop sequencer: phase counter, symbol strobe, fill/run/drain control
// Optional burst-length mode is enabled with the TX_SEQ_BURST_EN macro.
module tx_sequencer #(
    parameter int OVERSAMP = 4,
    parameter int NBAUD    = 6,
    parameter int NB_LEN   = 16,
    localparam int NB_PH   = $clog2(OVERSAMP)
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_stop,
`ifdef TX_SEQ_BURST_EN
    input  logic [NB_LEN-1:0] i_burst_len,
`endif
    output logic [NB_PH-1:0]  o_phase,
    output logic              o_sym_strobe,
    output logic              o_prbs_en,
    output logic              o_filt_en,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;

    localparam logic [NB_PH-1:0]  PH_LAST  = NB_PH'(OVERSAMP - 1);
    localparam logic [NB_LEN-1:0] SYM_LAST = NB_LEN'(NBAUD - 1);

    state_t            state;
    state_t            state_next;
    logic [NB_PH-1:0]  phase;
    logic [NB_LEN-1:0] sym_cnt;
    logic [NB_LEN-1:0] sym_cnt_inc;
    logic              stop_latch;
    logic              done_r;
    logic              strobe;
`ifdef TX_SEQ_BURST_EN
    logic [NB_LEN-1:0] burst_len_r;
`endif

    assign strobe      = (state != IDLE) && (phase == PH_LAST);
    assign sym_cnt_inc = (sym_cnt == '1) ? sym_cnt : sym_cnt + 1'b1;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_start && !i_stop) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (strobe && sym_cnt == SYM_LAST) begin
`ifdef TX_SEQ_BURST_EN
                    state_next = (burst_len_r == '0) ? DRAIN : RUN;
`else
                    state_next = RUN;
`endif
                end
            end
            RUN: begin
                if (strobe && stop_latch) begin
                    state_next = DRAIN;
                end
`ifdef TX_SEQ_BURST_EN
                else if (strobe && sym_cnt_inc >= burst_len_r) begin
                    state_next = DRAIN;
                end
`endif
            end
            DRAIN: begin
                if (strobe && sym_cnt == SYM_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counter restarts on every state change so each phase of the burst counts from zero.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            phase      <= '0;
            sym_cnt    <= '0;
            stop_latch <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            phase  <= (state == IDLE || phase == PH_LAST) ? '0 : phase + 1'b1;
            done_r <= (state == DRAIN) && (state_next == IDLE);
            if (state_next != state) begin
                sym_cnt <= '0;
            end else if (strobe) begin
                sym_cnt <= sym_cnt_inc;
            end
            if (state_next == IDLE) begin
                stop_latch <= 1'b0;
            end else if ((state == FILL || state == RUN) && i_stop) begin
                stop_latch <= 1'b1;
            end
        end
    end

`ifdef TX_SEQ_BURST_EN
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            burst_len_r <= '0;
        end else if (state == IDLE && state_next == FILL) begin
            burst_len_r <= i_burst_len;
        end
    end
`endif

    // A latched stop freezes the PRBS already at the closing RUN symbol.
    always_comb begin
        o_phase      = phase;
        o_busy       = (state != IDLE);
        o_sym_strobe = strobe;
        o_filt_en    = strobe;
        o_prbs_en    = strobe && ((state == FILL) || (state == RUN && !stop_latch));
        o_valid      = (state == RUN) || (state == DRAIN);
        o_done       = done_r;
    end

endmodule

// File: tb/tb_tx_sequencer.sv
// tb/tb_tx_sequencer.sv - scoreboard bench for tx_sequencer against a symbol-timeline model
module tb_tx_sequencer;

    localparam int OS = 4;
    localparam int NB = 6;
    localparam int NOSTOP = 100000;

    typedef struct packed {
        logic [1:0] phase;
        logic       strobe;
        logic       prbs;
        logic       filt;
        logic       valid;
        logic       busy;
        logic       done;
    } outs_t;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
`ifdef TX_SEQ_BURST_EN
    logic [15:0] i_burst_len = '0;
`endif
    logic [1:0]  o_phase;
    logic        o_sym_strobe, o_prbs_en, o_filt_en, o_valid, o_busy, o_done;

    outs_t exp_q[$];
    int    tests = 0;
    int    errors = 0;
    int    obs_prbs = 0;
    int    exp_prbs = 0;
    int    req_id = 0;
    int    seen_id = 0;

    tx_sequencer dut (
        .clk(clk), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop),
`ifdef TX_SEQ_BURST_EN
        .i_burst_len(i_burst_len),
`endif
        .o_phase(o_phase), .o_sym_strobe(o_sym_strobe), .o_prbs_en(o_prbs_en),
        .o_filt_en(o_filt_en), .o_valid(o_valid), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    // Number of RUN symbols: up to and including the first strobe that sees the stop latched.
    function automatic int run_symbols(input int s, input int t, input int l);
        int num, ns, n;
        num = t + 1 - s - OS;
        ns  = (num <= 0) ? 0 : (num + OS - 1) / OS;
        if (ns < NB) ns = NB;
        n = ns - NB + 1;
`ifdef TX_SEQ_BURST_EN
        if (l < n) n = l;
`endif
        return n;
    endfunction

    function automatic outs_t model(input int k, input int has_start, input int s,
                                    input int t, input int nrun, input bit rst);
        outs_t o;
        int c, n, ph, total;
        o = '0;
        if (rst || !has_start || k <= s) return o;
        c     = k - s - 1;
        n     = c / OS;
        ph    = c % OS;
        total = (2 * NB + nrun) * OS;
        if (c == total) begin
            o.done = 1'b1;
        end else if (c < total) begin
            o.busy   = 1'b1;
            o.phase  = 2'(ph);
            o.strobe = (ph == OS - 1);
            o.filt   = o.strobe;
            o.valid  = (n >= NB);
            o.prbs   = o.strobe && ((n < NB) || (n < NB + nrun && k <= t));
        end
        return o;
    endfunction

    always @(negedge clk) begin
        outs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {o_phase, o_sym_strobe, o_prbs_en, o_filt_en, o_valid, o_busy, o_done};
            tests++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got %b required %b (phase,strobe,prbs,filt,valid,busy,done)",
                         $time, a, e);
            end
            obs_prbs += int'(o_prbs_en);
        end else if (req_id != seen_id) begin
            seen_id = req_id;
            tests++;
            if (obs_prbs != exp_prbs) begin
                errors++;
                $display("FAIL prbs_count got %0d required %0d", obs_prbs, exp_prbs);
            end
            obs_prbs = 0;
        end
    end

    // r: cycle of mid-run reset (-1 none); both: start and stop together at s; xs: stray start.
    task automatic run_scn(input int has_start, input int s, input int t, input int l,
                           input int r, input bit both, input int xs);
        int nrun, last;
        bit rst;
        outs_t e;
        nrun = run_symbols(s, t, l);
        last = has_start ? s + 1 + (2 * NB + nrun) * OS + 3 : 50;
        if (r >= 0) last = r;
        exp_prbs = 0;
        for (int k = 0; k <= last; k++) begin
            @(posedge clk);
            #1;
            rst     = (k < 2) || (r >= 0 && k >= r);
            i_reset = rst;
            i_start = (has_start && k == s) || (both && k == s) || (k == xs);
            i_stop  = (k == t) || (both && k == s);
`ifdef TX_SEQ_BURST_EN
            i_burst_len = (k <= s) ? 16'(l) : 16'($urandom);
`endif
            e = model(k, has_start, s, t, nrun, rst);
            exp_prbs += int'(e.prbs);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_stop  = 1'b0;
        req_id++;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int s, t, l, nrun, xs;
        run_scn(0, 0, NOSTOP, 0, -1, 1'b0, -1);
        run_scn(1, 10, 40, 10, -1, 1'b0, -1);
        run_scn(0, 10, NOSTOP, 0, -1, 1'b1, -1);
        run_scn(1, 10, 60, 10, -1, 1'b0, 40);
        run_scn(1, 10, 40, 10, 45, 1'b0, -1);
        run_scn(1, 10, 40, 10, -1, 1'b0, -1);
        run_scn(1, 10, 20, 10, -1, 1'b0, -1);
`ifdef TX_SEQ_BURST_EN
        run_scn(1, 10, NOSTOP, 10, -1, 1'b0, -1);
        run_scn(1, 10, NOSTOP, 0, -1, 1'b0, -1);
`endif
        for (int i = 0; i < 16; i++) begin
            s = 3 + int'($urandom_range(0, 12));
            t = s + 1 + int'($urandom_range(0, (NB + 8) * OS));
            l = int'($urandom_range(0, 8));
`ifdef TX_SEQ_BURST_EN
            if ($urandom_range(0, 2) == 0) t = NOSTOP;
`endif
            nrun = run_symbols(s, t, l);
            xs = s + 2 + int'($urandom_range(0, (2 * NB + nrun) * OS - 2));
            run_scn(1, s, t, l, -1, 1'b0, xs);
        end
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
